// File: rtl/barrel_pkg.sv
// Shared types for the pipelined barrel shifter: shift-mode encoding and
// the width of the mode field carried down the pipeline.
package barrel_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_e;

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage of the barrel shifter. Applies a fixed shift of STEP
// bit positions when the matching shift-amount bit is set, otherwise passes
// the operand through, then registers data, mode, shift amount and valid.
// The whole stage freezes when advance is low so results stay stable under
// back-pressure. A registered zero flag of the stage result is also kept;
// the top level only exposes the flag of the final stage.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  shift_mode_e        in_mode,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output shift_mode_e        out_mode,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic               out_zero
);

  // Position of this stage's bit inside the shift amount.
  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] shifted;

  // Conditional fixed-distance shift; SRA copies the current MSB, which every
  // earlier stage has preserved, so it is still the original operand's sign.
  always_comb begin
    shifted = in_data;
    if (in_shamt[BIT]) begin
      case (in_mode)
        SH_SLL:  shifted = {in_data[WIDTH-1-STEP:0], {STEP{1'b0}}};
        SH_SRL:  shifted = {{STEP{1'b0}}, in_data[WIDTH-1:STEP]};
        SH_SRA:  shifted = {{STEP{in_data[WIDTH-1]}}, in_data[WIDTH-1:STEP]};
        SH_ROR:  shifted = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
        default: shifted = in_data;
      endcase
    end
  end

  // Stage register: valid follows the predecessor on every advance, while the
  // payload only loads for a real beat so bubbles never pull in undriven data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= SH_SLL;
      out_shamt <= '0;
      out_zero  <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data  <= shifted;
        out_mode  <= in_mode;
        out_shamt <= in_shamt;
        out_zero  <= (shifted == '0);
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with a valid/ready stream interface. One stage per
// shift-amount bit (stage k shifts by 2^k), so latency is SHAMT_W cycles and
// throughput is one beat per cycle. A single global advance signal moves the
// whole pipeline together; bubbles are not compressed.
// Optional feature: define BARREL_ZFLAG_EN to add the registered out_zero
// flag (high when out_data is zero, meaningful only with out_valid).
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef BARREL_ZFLAG_EN
  ,
  output logic               out_zero
`endif
);

  // Index 0 is the input beat; index k+1 is the register of stage k.
  logic               stage_valid [SHAMT_W+1];
  logic [WIDTH-1:0]   stage_data  [SHAMT_W+1];
  shift_mode_e        stage_mode  [SHAMT_W+1];
  logic [SHAMT_W-1:0] stage_shamt [SHAMT_W+1];
  logic [SHAMT_W-1:0] stage_zero;
  logic               advance;
  logic               unused_tail;

  // The pipeline moves whenever the output slot is empty or being drained.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  assign stage_valid[0] = in_valid;
  assign stage_data[0]  = in_data;
  assign stage_mode[0]  = shift_mode_e'(in_mode);
  assign stage_shamt[0] = in_shamt;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_stage #(
      .WIDTH   (WIDTH),
      .STEP    (1 << k),
      .SHAMT_W (SHAMT_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .advance   (advance),
      .in_valid  (stage_valid[k]),
      .in_data   (stage_data[k]),
      .in_mode   (stage_mode[k]),
      .in_shamt  (stage_shamt[k]),
      .out_valid (stage_valid[k+1]),
      .out_data  (stage_data[k+1]),
      .out_mode  (stage_mode[k+1]),
      .out_shamt (stage_shamt[k+1]),
      .out_zero  (stage_zero[k])
    );
  end

  assign out_valid = stage_valid[SHAMT_W];
  assign out_data  = stage_data[SHAMT_W];

`ifdef BARREL_ZFLAG_EN
  assign out_zero = stage_zero[SHAMT_W-1];
`endif

  // Mode/shift amount of the last stage and intermediate zero flags have no
  // consumer; they are gathered here so the synthesiser can trim them.
  assign unused_tail = ^{stage_mode[SHAMT_W], stage_shamt[SHAMT_W], stage_zero};

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined barrel shifter. Generalises the 4-bit combinational left/right shifter to WIDTH bits and four shift modes: logical left, logical right, arithmetic right, rotate right.
- One pipeline register per shift-amount bit.
- Valid/ready streaming handshake, so it drops into datapaths with back-pressure (ALU shift unit, normalisation paths).

Parameters:
- WIDTH, 8, data width in bits; must be a power of 2, >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages; derived, not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, all stage data/mode/shamt registers = 0, so out_valid = 0 and out_data = 0.
- Pipeline shape:
  - Stage k (k = 0..SHAMT_W-1) applies a shift of 2^k when shamt[k] = 1, otherwise passes data through.
  - Each stage registers data, mode, remaining shamt and valid.
- Latency: a beat accepted on edge N is presented on out_data/out_valid after edge N+SHAMT_W-1, i.e. SHAMT_W register stages. For WIDTH = 8 that is 3 cycles with no stall.
- Global advance: advance = out_ready OR NOT out_valid. in_ready = advance.
  - When advance = 1, all stages load from their predecessor and stage 0 loads the input beat (valid = in_valid AND in_ready).
  - When advance = 0, every stage holds.
  - Bubbles are not compressed.
- A transfer occurs only when valid AND ready. in_data, in_mode and in_shamt are sampled only on an input transfer.
- While out_valid = 1 and out_ready = 0, out_data must remain stable.
- Mode rules, per stage:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: replicate the original operand MSB. The sign travels with the data and remains correct because each stage preserves the MSB.
  - ROR: bits leaving the LSB re-enter at the MSB.
- shamt = 0: out_data = in_data for every mode.
- Simultaneous events: in the same cycle, an input transfer and an output transfer with out_ready = 1 are both accepted. Throughput is 1 beat/cycle.
- Reset mid-operation: in-flight beats are discarded, with no partial output.
- No X propagation: stage data registers load only when advance = 1.

Optional Feature:
- Macro: BARREL_ZFLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit), registered alongside out_data.
  - out_zero = 1 iff out_data == 0. Valid only with out_valid.
  - Resets to 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package barrel_pkg holds:
  - enum shift_mode_e {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROR = 2'b11};
  - localparam MODE_W = 2.
- Sub-module barrel_stage (parameters WIDTH, STEP = 2^k) contains one conditional fixed-distance shift for all four modes plus its stage register and hold-on-stall logic.
- Top level instantiates SHAMT_W barrel_stage instances via generate and holds the handshake logic.

Test Plan (WIDTH = 8, latency 3):
- SLL: in_data = 1001_0110, in_shamt = 3 -> out_data = 1011_0000 three cycles later. SRL with shamt = 3 -> 0001_0010.
- SRA and ROR: 1001_0110 SRA 2 -> 1110_0101; ROR 1 -> 0100_1011; ROR 3 -> 1101_0010; any mode with shamt = 0 -> 1001_0110.
- Back-to-back with back-pressure:
  - Stream 6 beats with in_valid held at 1 and out_ready toggling 1,0,0,1,...
  - Required: every result is in order; out_data is stable while stalled; in_ready = 0 exactly when out_valid = 1 and out_ready = 0; no beat is lost or duplicated.
- Reset mid-stream: assert rst_n = 0 with 3 beats in flight -> out_valid = 0 and out_data = 0 immediately (async). After release, the first new beat emerges with 3-cycle latency and no stale data.
- Full-range sweep: all 256 operands × 8 shamts × 4 modes compared against a reference model, including SRA of 1000_0000 by 7 -> 1111_1111.
- With BARREL_ZFLAG_EN defined:
  - 1001_0110 SLL 7 -> out_data = 0000_0000, out_zero = 1.
  - SLL 1 -> out_zero = 0.
